// File: rtl/decode_pkg.sv
// decode_pkg: shared types and encodings for the RV32I/M decode stage.
//   alu_op_t   - ALU operation selector
//   OPC_*      - major opcode values (instr[6:0])
//   IMM_*      - immediate format selector for downstream immediate generation
//   SRC_A_*    - ALU operand A source
//   RES_*      - write-back result source
//   ctrl_t     - complete control bundle produced by the decoder
package decode_pkg;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_I    = 3'b001;
    localparam logic [2:0] IMM_S    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;
    localparam logic [2:0] IMM_J    = 3'b101;

    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    typedef struct packed {
        logic       reg_write;
        logic [2:0] imm_src;
        logic [1:0] alu_src_a;
        logic       alu_src_b;    // 0 = rs2, 1 = immediate
        alu_op_t    alu_op;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_size;     // raw funct3
        logic [1:0] result_src;
        logic       branch;
        logic [2:0] branch_cond;  // raw funct3
        logic       jump;
        logic       jalr;
        logic       illegal;
    } ctrl_t;

    // Base integer op from funct3; alt selects SUB/SRA for funct3 000/101.
    function automatic alu_op_t base_alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  base_alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  base_alu_op = ALU_SLL;
            3'b010:  base_alu_op = ALU_SLT;
            3'b011:  base_alu_op = ALU_SLTU;
            3'b100:  base_alu_op = ALU_XOR;
            3'b101:  base_alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  base_alu_op = ALU_OR;
            default: base_alu_op = ALU_AND;
        endcase
    endfunction

    function automatic alu_op_t muldiv_alu_op(input logic [2:0] f3);
        case (f3)
            3'b000:  muldiv_alu_op = ALU_MUL;
            3'b001:  muldiv_alu_op = ALU_MULH;
            3'b010:  muldiv_alu_op = ALU_MULHSU;
            3'b011:  muldiv_alu_op = ALU_MULHU;
            3'b100:  muldiv_alu_op = ALU_DIV;
            3'b101:  muldiv_alu_op = ALU_DIVU;
            3'b110:  muldiv_alu_op = ALU_REM;
            default: muldiv_alu_op = ALU_REMU;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// ctrl_decode_comb: purely combinational RV32I (+ optional RV32M) control decoder.
//   instr  in   32-bit instruction word
//   ctrl   out  decoded control bundle; illegal encodings set ctrl.illegal and
//               have reg_write/mem_read/mem_write/branch/jump forced low
module ctrl_decode_comb
    import decode_pkg::*;
#(
    parameter bit EN_M = 1'b0
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       illegal;
    ctrl_t      c;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    // Register index fields are carried by the stage, not decoded here.
    assign unused_bits = ^{instr[24:15], instr[11:7]};

    always_comb begin
        c             = '0;
        illegal       = 1'b0;
        c.mem_size    = funct3;
        c.branch_cond = funct3;
        case (opcode)
            OPC_LOAD: begin
                c.reg_write  = 1'b1;
                c.imm_src    = IMM_I;
                c.alu_src_b  = 1'b1;
                c.mem_read   = 1'b1;
                c.result_src = RES_MEM;
                illegal      = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_OP_IMM: begin
                c.reg_write = 1'b1;
                c.imm_src   = IMM_I;
                c.alu_src_b = 1'b1;
                // Only shifts use funct7; addi etc. carry immediate bits there.
                c.alu_op    = base_alu_op(funct3, (funct3 == 3'b101) && funct7[5]);
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != F7_BASE);
                end else if (funct3 == 3'b101) begin
                    illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                end
            end
            OPC_STORE: begin
                c.imm_src   = IMM_S;
                c.alu_src_b = 1'b1;
                c.mem_write = 1'b1;
                illegal     = (funct3 > 3'b010);
            end
            OPC_OP: begin
                c.reg_write = 1'b1;
                if (funct7 == F7_BASE) begin
                    c.alu_op = base_alu_op(funct3, 1'b0);
                end else if (funct7 == F7_ALT) begin
                    c.alu_op = base_alu_op(funct3, 1'b1);
                    illegal  = (funct3 != 3'b000) && (funct3 != 3'b101);
                end else if (EN_M && (funct7 == F7_MULDIV)) begin
                    c.alu_op = muldiv_alu_op(funct3);
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_BRANCH: begin
                c.imm_src = IMM_B;
                c.branch  = 1'b1;
                c.alu_op  = ALU_SUB;
                illegal   = (funct3[2:1] == 2'b01);
            end
            OPC_LUI: begin
                c.reg_write = 1'b1;
                c.imm_src   = IMM_U;
                c.alu_src_a = SRC_A_ZERO;
                c.alu_src_b = 1'b1;
            end
            OPC_AUIPC: begin
                c.reg_write = 1'b1;
                c.imm_src   = IMM_U;
                c.alu_src_a = SRC_A_PC;
                c.alu_src_b = 1'b1;
            end
            OPC_JAL: begin
                c.reg_write  = 1'b1;
                c.imm_src    = IMM_J;
                c.alu_src_a  = SRC_A_PC;
                c.alu_src_b  = 1'b1;
                c.result_src = RES_PC4;
                c.jump       = 1'b1;
            end
            OPC_JALR: begin
                c.reg_write  = 1'b1;
                c.imm_src    = IMM_I;
                c.alu_src_a  = SRC_A_RS1;
                c.alu_src_b  = 1'b1;
                c.result_src = RES_PC4;
                c.jump       = 1'b1;
                c.jalr       = 1'b1;
                illegal      = (funct3 != 3'b000);
            end
            default: illegal = 1'b1;
        endcase

        // An illegal word still travels down the pipe but must not change state.
        if (illegal) begin
            c.reg_write = 1'b0;
            c.mem_read  = 1'b0;
            c.mem_write = 1'b0;
            c.branch    = 1'b0;
            c.jump      = 1'b0;
        end
        c.illegal = illegal;
    end

    assign ctrl = c;

endmodule

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered, handshaked decode stage between fetch and execute.
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous kill of all buffered entries
//   in_valid/in_ready   upstream handshake carrying instr and pc
//   out_valid/out_ready downstream handshake carrying the decoded entry
//   out_ctrl            decoded control bundle
//   out_rd/rs1/rs2      register indices taken from the instruction
//   out_pc, out_instr   pass-through of pc and the raw word
//
// Handshake: a beat moves on a rising edge where valid && ready are both high.
// A producer holds valid and its payload until that edge; ready never depends on
// valid from the same side. out_* payload is stable while out_valid && !out_ready.
// With SKID=1 in_ready is a register (= skid empty); with SKID=0 it is
// !out_valid || out_ready.
module ctrl_decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit EN_M = 1'b0,
    parameter bit SKID = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output ctrl_t           out_ctrl,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr
);

    typedef struct packed {
        ctrl_t            ctrl;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [XLEN-1:0]  pc;
        logic [31:0]      instr;
    } entry_t;

    ctrl_t  dec_ctrl;
    entry_t in_entry;
    entry_t out_q;
    entry_t skid_q;
    logic   out_valid_q;
    logic   skid_valid_q;
    logic   in_ready_q;
    logic   accept;

    ctrl_decode_comb #(.EN_M(EN_M)) u_decode (
        .instr (instr),
        .ctrl  (dec_ctrl)
    );

    always_comb begin
        in_entry       = '0;
        in_entry.ctrl  = dec_ctrl;
        in_entry.rd    = instr[11:7];
        in_entry.rs1   = instr[19:15];
        in_entry.rs2   = instr[24:20];
        in_entry.pc    = pc;
        in_entry.instr = instr;
    end

    assign in_ready = SKID ? in_ready_q : (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // The skid slot is only written when the output is stalled and a beat is
    // accepted; with SKID=0 in_ready is low in that situation, so it stays empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (!out_valid_q || out_ready) begin
            // Output slot frees this edge: the older skid entry wins over new input.
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                out_q       <= in_entry;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
            in_ready_q <= 1'b1;
        end else if (accept) begin
            skid_q       <= in_entry;
            skid_valid_q <= 1'b1;
            in_ready_q   <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ctrl  = out_q.ctrl;
    assign out_rd    = out_q.rd;
    assign out_rs1   = out_q.rs1;
    assign out_rs2   = out_q.rs2;
    assign out_pc    = out_q.pc;
    assign out_instr = out_q.instr;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
module tb_ctrl_decode_stage;
    import decode_pkg::*;

    localparam int XLEN = 32;
    localparam int W    = $bits(ctrl_t) + 15 + XLEN + 32;
    localparam int NTBL = 12;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- DUT signals ----------------
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [31:0]     instr = '0;
    logic [XLEN-1:0] pc = '0;
    logic            in_ready, out_valid;
    ctrl_t           out_ctrl;
    logic [4:0]      out_rd, out_rs1, out_rs2;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;

    logic            m_in_valid = 1'b0;
    logic            m_out_ready = 1'b0;
    logic            m_in_ready, m_out_valid;
    ctrl_t           m_ctrl;
    logic [4:0]      m_rd, m_rs1, m_rs2;
    logic [XLEN-1:0] m_pc;
    logic [31:0]     m_instr;

    ctrl_decode_stage #(.XLEN(XLEN), .EN_M(1'b0), .SKID(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_pc(out_pc), .out_instr(out_instr)
    );

    ctrl_decode_stage #(.XLEN(XLEN), .EN_M(1'b1), .SKID(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .instr(instr), .pc(pc),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_ctrl(m_ctrl),
        .out_rd(m_rd), .out_rs1(m_rs1), .out_rs2(m_rs2),
        .out_pc(m_pc), .out_instr(m_instr)
    );

    // ---------------- scoreboard ----------------
    int         total = 0;
    int         bad = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_got;

    logic [31:0] tbl_instr[NTBL];
    ctrl_t       tbl_ctrl[NTBL];

    function automatic ctrl_t mk(input logic rw, input logic [2:0] imm, input logic [1:0] a,
                                 input logic b, input alu_op_t op, input logic mr, input logic mw,
                                 input logic [2:0] sz, input logic [1:0] res, input logic br,
                                 input logic [2:0] bc, input logic j, input logic jr, input logic ill);
        ctrl_t c;
        c.reg_write = rw;  c.imm_src = imm;   c.alu_src_a = a;    c.alu_src_b = b;
        c.alu_op = op;     c.mem_read = mr;   c.mem_write = mw;   c.mem_size = sz;
        c.result_src = res; c.branch = br;    c.branch_cond = bc; c.jump = j;
        c.jalr = jr;       c.illegal = ill;
        return c;
    endfunction

    function automatic logic [W-1:0] ent(input ctrl_t c, input logic [31:0] ins, input logic [XLEN-1:0] p);
        return {c, ins[11:7], ins[19:15], ins[24:20], p, ins};
    endfunction

    task automatic init_tbl();
        tbl_instr[0]  = 32'h00510093; // addi x1,x2,5
        tbl_ctrl[0]   = mk(1, IMM_I, SRC_A_RS1, 1, ALU_ADD, 0, 0, 3'b000, RES_ALU, 0, 3'b000, 0, 0, 0);
        tbl_instr[1]  = 32'h402081B3; // sub x3,x1,x2
        tbl_ctrl[1]   = mk(1, IMM_NONE, SRC_A_RS1, 0, ALU_SUB, 0, 0, 3'b000, RES_ALU, 0, 3'b000, 0, 0, 0);
        tbl_instr[2]  = 32'h0080A283; // lw x5,8(x1)
        tbl_ctrl[2]   = mk(1, IMM_I, SRC_A_RS1, 1, ALU_ADD, 1, 0, 3'b010, RES_MEM, 0, 3'b010, 0, 0, 0);
        tbl_instr[3]  = 32'h008000EF; // jal x1,+8
        tbl_ctrl[3]   = mk(1, IMM_J, SRC_A_PC, 1, ALU_ADD, 0, 0, 3'b000, RES_PC4, 0, 3'b000, 1, 0, 0);
        tbl_instr[4]  = 32'h022081B3; // mul x3,x1,x2 without M
        tbl_ctrl[4]   = mk(0, IMM_NONE, SRC_A_RS1, 0, ALU_ADD, 0, 0, 3'b000, RES_ALU, 0, 3'b000, 0, 0, 1);
        tbl_instr[5]  = 32'hFFFFFFFF; // unknown opcode
        tbl_ctrl[5]   = mk(0, IMM_NONE, SRC_A_RS1, 0, ALU_ADD, 0, 0, 3'b111, RES_ALU, 0, 3'b111, 0, 0, 1);
        tbl_instr[6]  = 32'h0020B023; // store funct3 011
        tbl_ctrl[6]   = mk(0, IMM_S, SRC_A_RS1, 1, ALU_ADD, 0, 0, 3'b011, RES_ALU, 0, 3'b011, 0, 0, 1);
        tbl_instr[7]  = 32'h00208463; // beq x1,x2,+8
        tbl_ctrl[7]   = mk(0, IMM_B, SRC_A_RS1, 0, ALU_SUB, 0, 0, 3'b000, RES_ALU, 1, 3'b000, 0, 0, 0);
        tbl_instr[8]  = 32'h0020A063; // branch funct3 010
        tbl_ctrl[8]   = mk(0, IMM_B, SRC_A_RS1, 0, ALU_SUB, 0, 0, 3'b010, RES_ALU, 0, 3'b010, 0, 0, 1);
        tbl_instr[9]  = 32'h123452B7; // lui x5,0x12345
        tbl_ctrl[9]   = mk(1, IMM_U, SRC_A_ZERO, 1, ALU_ADD, 0, 0, 3'b101, RES_ALU, 0, 3'b101, 0, 0, 0);
        tbl_instr[10] = 32'h000100E7; // jalr x1,0(x2)
        tbl_ctrl[10]  = mk(1, IMM_I, SRC_A_RS1, 1, ALU_ADD, 0, 0, 3'b000, RES_PC4, 0, 3'b000, 1, 1, 0);
        tbl_instr[11] = 32'h40315093; // srai x1,x2,3
        tbl_ctrl[11]  = mk(1, IMM_I, SRC_A_RS1, 1, ALU_SRA, 0, 0, 3'b101, RES_ALU, 0, 3'b101, 0, 0, 0);
    endtask

    // Output monitor: every consumed beat is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            mon_got = {out_ctrl, out_rd, out_rs1, out_rs2, out_pc, out_instr};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected got=%h required=none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    bad++;
                    $display("FAIL out_entry got=%h required=%h", mon_got, mon_exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int k, input logic [XLEN-1:0] p);
        logic acc;
        bit   done;
        done     = 0;
        in_valid = 1'b1;
        instr    = tbl_instr[k];
        pc       = p;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back(ent(tbl_ctrl[k], tbl_instr[k], p));
                done = 1;
            end
        end
        #1;
        in_valid = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("FAIL send_timeout got in_ready=0 required=1");
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got left=%0d required=0", exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
        total++; if (out_ctrl !== '0) begin bad++; $display("FAIL reset_out_ctrl got=%h required=0", out_ctrl); end
        total++;
        if ({out_rd, out_rs1, out_rs2, out_pc, out_instr} !== '0) begin
            bad++; $display("FAIL reset_payload got=%h required=0", {out_rd, out_rs1, out_rs2, out_pc, out_instr});
        end
        total++; if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin bad++; $display("FAIL reset_m got v=%b r=%b required v=0 r=1", m_out_valid, m_in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        send(0, 32'h0000_1000);
        // One edge after acceptance the bundle is already presented.
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%b required=1", out_valid); end
        total++;
        if (out_ctrl.alu_op !== ALU_ADD || out_ctrl.alu_src_b !== 1'b1 || out_ctrl.imm_src !== IMM_I ||
            out_ctrl.reg_write !== 1'b1 || out_ctrl.illegal !== 1'b0) begin
            bad++; $display("FAIL lat_addi_ctrl got=%h required=%h", out_ctrl, tbl_ctrl[0]);
        end
        total++; if (out_rd !== 5'd1 || out_rs1 !== 5'd2) begin bad++; $display("FAIL lat_regs got rd=%0d rs1=%0d required rd=1 rs1=2", out_rd, out_rs1); end
        drain();
    endtask

    task automatic test_decode();
        out_ready = 1'b1;
        send(1, 32'h0000_2000);
        send(2, 32'h0000_2004);
        send(3, 32'h0000_2008);
        send(7, 32'h0000_200C);
        send(9, 32'h0000_2010);
        send(10, 32'h0000_2014);
        send(11, 32'h0000_2018);
        drain();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        send(4, 32'h0000_3000);
        total++; if (out_ctrl.illegal !== 1'b1 || out_ctrl.reg_write !== 1'b0) begin bad++; $display("FAIL mul_no_m got ill=%b rw=%b required ill=1 rw=0", out_ctrl.illegal, out_ctrl.reg_write); end
        send(5, 32'h0000_3004);
        total++; if (out_ctrl.illegal !== 1'b1) begin bad++; $display("FAIL all_ones got ill=%b required=1", out_ctrl.illegal); end
        send(6, 32'h0000_3008);
        send(8, 32'h0000_300C);
        drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1; instr = tbl_instr[0]; pc = 32'h0000_4000;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_c1 got=%b required=1", in_ready); end
        @(posedge clk); exp_q.push_back(ent(tbl_ctrl[0], tbl_instr[0], 32'h0000_4000)); #1;
        instr = tbl_instr[1]; pc = 32'h0000_4004;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_c2 got v=%b r=%b required v=1 r=1", out_valid, in_ready); end
        @(posedge clk); exp_q.push_back(ent(tbl_ctrl[1], tbl_instr[1], 32'h0000_4004)); #1;
        instr = tbl_instr[2]; pc = 32'h0000_4008;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_c3 got=%b required=0", in_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (in_ready !== 1'b0 || out_instr !== tbl_instr[0]) begin bad++; $display("FAIL bp_hold got r=%b instr=%h required r=0 instr=%h", in_ready, out_instr, tbl_instr[0]); end
        @(posedge clk); #1;
        out_ready = 1'b1;                 // A leaves on the next edge
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || out_instr !== tbl_instr[1]) begin bad++; $display("FAIL bp_b_out got r=%b instr=%h required r=1 instr=%h", in_ready, out_instr, tbl_instr[1]); end
        @(posedge clk); exp_q.push_back(ent(tbl_ctrl[2], tbl_instr[2], 32'h0000_4008)); #1;
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_instr !== tbl_instr[2]) begin bad++; $display("FAIL bp_c_out got v=%b instr=%h required v=1 instr=%h", out_valid, out_instr, tbl_instr[2]); end
        drain();
    endtask

    task automatic test_back_to_back();
        int c0;
        out_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 8; i++) send(i % NTBL, 32'h0000_5000 + 32'(i * 4));
        total++; if (cyc - c0 != 8) begin bad++; $display("FAIL b2b_throughput got=%0d required=8", cyc - c0); end
        drain();
    endtask

    task automatic test_random();
        bit drv_done;
        drv_done = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) send($urandom_range(0, NTBL - 1), $urandom());
                drv_done = 1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        drain();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send(0, 32'h0000_6000);
        send(1, 32'h0000_6004);           // A at output, B in skid
        in_valid = 1'b1; instr = tbl_instr[2]; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b required=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b required=1", in_ready); end
        // An acceptable beat presented during flush must be dropped too.
        in_valid = 1'b1; instr = tbl_instr[3]; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_output got=%b required=0", out_valid); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mul_m();
        m_out_ready = 1'b0;
        m_in_valid = 1'b1; instr = tbl_instr[4]; pc = 32'h0000_7000;
        @(negedge clk);
        total++; if (m_in_ready !== 1'b1) begin bad++; $display("FAIL m_ready_empty got=%b required=1", m_in_ready); end
        @(posedge clk); #1;
        m_in_valid = 1'b0;
        total++; if (m_out_valid !== 1'b1) begin bad++; $display("FAIL m_valid got=%b required=1", m_out_valid); end
        total++;
        if (m_ctrl !== mk(1, IMM_NONE, SRC_A_RS1, 0, ALU_MUL, 0, 0, 3'b000, RES_ALU, 0, 3'b000, 0, 0, 0)) begin
            bad++; $display("FAIL m_mul_ctrl got=%h required alu_op=MUL rw=1 ill=0", m_ctrl);
        end
        total++; if (m_rd !== 5'd3 || m_pc !== 32'h0000_7000) begin bad++; $display("FAIL m_payload got rd=%0d pc=%h required rd=3 pc=00007000", m_rd, m_pc); end
        total++; if (m_in_ready !== 1'b0) begin bad++; $display("FAIL m_ready_stall got=%b required=0", m_in_ready); end
        m_out_ready = 1'b1;
        #1;
        total++; if (m_in_ready !== 1'b1) begin bad++; $display("FAIL m_ready_comb got=%b required=1", m_in_ready); end
        @(posedge clk); #1;
        total++; if (m_out_valid !== 1'b0) begin bad++; $display("FAIL m_drained got=%b required=0", m_out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send(2, 32'h0000_8000);
        send(3, 32'h0000_8004);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL async_reset got v=%b r=%b required v=0 r=1", out_valid, in_ready); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        init_tbl();
        test_reset();
        test_latency();
        test_decode();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_flush();
        test_mul_m();
        test_async_reset();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d required=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
